// File: rtl/lv_wdg_scan_rsp.sv
// Register-bank responder for the LV watchdog scan: arbitrates against SPI, reads the bank, returns
// data plus CRC8. Optional macro LV_WDG_SCAN_CRC_INJ_EN adds a CRC bit-0 error injection input.
module lv_wdg_scan_rsp #(
   parameter int unsigned REG_AW    = 7,
   parameter int unsigned REG_DW    = 8,
   parameter int unsigned REG_CRC_W = 8,
   parameter int unsigned RD_LAT    = 1,
   parameter int unsigned WAIT_MAX  = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_wdg_scan_reg_rd_req,
   input  logic [REG_AW-1:0]    i_wdg_scan_reg_addr,
   output logic                 o_reg_wdg_scan_ack,
   output logic [REG_DW-1:0]    o_reg_wdg_scan_data,
   output logic [REG_CRC_W-1:0] o_reg_wdg_scan_crc,
   input  logic                 i_spi_reg_busy,
   output logic                 o_rb_rd_en,
   output logic [REG_AW-1:0]    o_rb_rd_addr,
   input  logic [REG_DW-1:0]    i_rb_rd_data,
`ifdef LV_WDG_SCAN_CRC_INJ_EN
   input  logic                 i_scan_crc_inj,
`endif
   output logic                 o_scan_bus_starve
);

   localparam int unsigned MSG_W  = 1 + REG_AW + REG_DW;
   localparam int unsigned LAT_W  = $clog2(RD_LAT + 1);
   localparam int unsigned WAIT_W = $clog2(WAIT_MAX);

   localparam logic [LAT_W-1:0]     LatLast = LAT_W'(RD_LAT);
   localparam logic [WAIT_W-1:0]    WaitTop = WAIT_W'(WAIT_MAX - 1);
   localparam logic [WAIT_W-1:0]    WaitPre = WAIT_W'(WAIT_MAX - 2);
   localparam logic [REG_CRC_W-1:0] CrcPoly = REG_CRC_W'(8'h07);

   typedef enum logic [2:0] {
      StIdle,
      StWaitBus,
      StRead,
      StResp,
      StHold
   } state_e;

   state_e                 state_q, state_d;
   logic [LAT_W-1:0]       lat_cnt_q, lat_cnt_d;
   logic [WAIT_W-1:0]      wait_cnt_q, wait_cnt_d;
   logic                   abort_q, abort_d;
   logic [REG_AW-1:0]      addr_q, addr_d;
   logic                   rd_en_q, rd_en_d;
   logic                   ack_q, ack_d;
   logic [REG_DW-1:0]      data_q, data_d;
   logic [REG_CRC_W-1:0]   crc_q, crc_d;
   logic                   starve_q, starve_d;
   logic                   crc_inj;

`ifdef LV_WDG_SCAN_CRC_INJ_EN
   assign crc_inj = i_scan_crc_inj;
`else
   assign crc_inj = 1'b0;
`endif

   // MSB-first CRC8, poly x^8+x^2+x+1, zero init, over the {1, addr, data} message.
   function automatic logic [REG_CRC_W-1:0] crc16to8_parallel(input logic [MSG_W-1:0] msg);
      logic [REG_CRC_W-1:0] crc;
      crc = '0;
      for (int i = MSG_W - 1; i >= 0; i--) begin
         if (crc[REG_CRC_W-1] ^ msg[i]) begin
            crc = (crc << 1) ^ CrcPoly;
         end else begin
            crc = crc << 1;
         end
      end
      return crc;
   endfunction

   always_comb begin
      state_d    = state_q;
      lat_cnt_d  = lat_cnt_q;
      wait_cnt_d = wait_cnt_q;
      abort_d    = abort_q;
      addr_d     = addr_q;
      data_d     = data_q;
      crc_d      = crc_q;
      rd_en_d    = 1'b0;
      ack_d      = 1'b0;
      starve_d   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (i_wdg_scan_reg_rd_req) begin
               if (!i_spi_reg_busy) begin
                  state_d   = StRead;
                  addr_d    = i_wdg_scan_reg_addr;
                  rd_en_d   = 1'b1;
                  lat_cnt_d = '0;
                  abort_d   = 1'b0;
               end else begin
                  state_d    = StWaitBus;
                  wait_cnt_d = '0;
               end
            end
         end

         StWaitBus: begin
            if (!i_wdg_scan_reg_rd_req) begin
               state_d    = StIdle;
               wait_cnt_d = '0;
            end else if (!i_spi_reg_busy) begin
               state_d    = StRead;
               addr_d     = i_wdg_scan_reg_addr;
               rd_en_d    = 1'b1;
               lat_cnt_d  = '0;
               abort_d    = 1'b0;
               wait_cnt_d = '0;
            end else if (wait_cnt_q != WaitTop) begin
               // Pulse lands in the cycle the counter reaches its top value; it then saturates.
               wait_cnt_d = wait_cnt_q + WAIT_W'(1);
               starve_d   = (wait_cnt_q == WaitPre);
            end
         end

         StRead: begin
            // Bank port stays with the scan until the read completes, even if SPI asserts busy.
            if (!i_wdg_scan_reg_rd_req) begin
               abort_d = 1'b1;
            end
            if (lat_cnt_q == LatLast) begin
               lat_cnt_d = '0;
               if (abort_q || !i_wdg_scan_reg_rd_req) begin
                  state_d = StIdle;
               end else begin
                  state_d = StResp;
                  ack_d   = 1'b1;
                  data_d  = i_rb_rd_data;
                  // Injection is sampled on the edge that enters StResp so the CRC stays registered.
                  crc_d   = crc16to8_parallel({1'b1, addr_q, i_rb_rd_data})
                            ^ {{(REG_CRC_W-1){1'b0}}, crc_inj};
               end
            end else begin
               lat_cnt_d = lat_cnt_q + LAT_W'(1);
            end
         end

         StResp: begin
            state_d = i_wdg_scan_reg_rd_req ? StHold : StIdle;
         end

         StHold: begin
            if (!i_wdg_scan_reg_rd_req) begin
               state_d = StIdle;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= StIdle;
         lat_cnt_q  <= '0;
         wait_cnt_q <= '0;
         abort_q    <= 1'b0;
         addr_q     <= '0;
         rd_en_q    <= 1'b0;
         ack_q      <= 1'b0;
         data_q     <= '0;
         crc_q      <= '0;
         starve_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         lat_cnt_q  <= lat_cnt_d;
         wait_cnt_q <= wait_cnt_d;
         abort_q    <= abort_d;
         addr_q     <= addr_d;
         rd_en_q    <= rd_en_d;
         ack_q      <= ack_d;
         data_q     <= data_d;
         crc_q      <= crc_d;
         starve_q   <= starve_d;
      end
   end

   assign o_reg_wdg_scan_ack  = ack_q;
   assign o_reg_wdg_scan_data = data_q;
   assign o_reg_wdg_scan_crc  = crc_q;
   assign o_rb_rd_en          = rd_en_q;
   assign o_rb_rd_addr        = addr_q;
   assign o_scan_bus_starve   = starve_q;

endmodule

// File: tb/tb_lv_wdg_scan_rsp.sv
// Directed bench for lv_wdg_scan_rsp: 1-cycle bank model, cycle-stamped monitor, CRC8 reference
// computed by polynomial long division.
module tb_lv_wdg_scan_rsp;

   localparam int RD_LAT   = 1;
   localparam int WAIT_MAX = 16;

   logic       i_clk = 1'b0;
   logic       i_rst = 1'b1;
   logic       req   = 1'b0;
   logic [6:0] addr  = '0;
   logic       busy  = 1'b0;
   logic       crc_inj = 1'b0;
   logic [7:0] rb_data = '0;
   logic       ack, rd_en, starve;
   logic [7:0] rsp_data, rsp_crc;
   logic [6:0] rd_addr;

   lv_wdg_scan_rsp #(
      .REG_AW    (7),
      .REG_DW    (8),
      .REG_CRC_W (8),
      .RD_LAT    (RD_LAT),
      .WAIT_MAX  (WAIT_MAX)
   ) dut (
      .i_clk                 (i_clk),
      .i_rst                 (i_rst),
      .i_wdg_scan_reg_rd_req (req),
      .i_wdg_scan_reg_addr   (addr),
      .o_reg_wdg_scan_ack    (ack),
      .o_reg_wdg_scan_data   (rsp_data),
      .o_reg_wdg_scan_crc    (rsp_crc),
      .i_spi_reg_busy        (busy),
      .o_rb_rd_en            (rd_en),
      .o_rb_rd_addr          (rd_addr),
      .i_rb_rd_data          (rb_data),
`ifdef LV_WDG_SCAN_CRC_INJ_EN
      .i_scan_crc_inj        (crc_inj),
`endif
      .o_scan_bus_starve     (starve)
   );

   always #5 i_clk = ~i_clk;

   // Bank with one cycle of latency; drives a junk pattern whenever no read is in flight.
   logic [7:0] mem [128];
   always @(posedge i_clk) rb_data <= rd_en ? mem[rd_addr] : 8'hEE;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int t0 = 0;
   int n_ack, ack_cyc, n_rd, rd_cyc, n_stv, stv_cyc;
   logic [7:0] ack_data, ack_crc;
   logic [6:0] rd_addr_seen;

   always @(posedge i_clk) cyc <= cyc + 1;

   always @(negedge i_clk) begin
      if (ack) begin
         if (n_ack == 0) begin
            ack_cyc  = cyc - t0;
            ack_data = rsp_data;
            ack_crc  = rsp_crc;
         end
         n_ack++;
      end
      if (rd_en) begin
         if (n_rd == 0) begin
            rd_cyc       = cyc - t0;
            rd_addr_seen = rd_addr;
         end
         n_rd++;
      end
      if (starve) begin
         if (n_stv == 0) stv_cyc = cyc - t0;
         n_stv++;
      end
   end

   function automatic logic [7:0] crc_model(input logic [15:0] msg);
      logic [23:0] rem;
      rem = {msg, 8'h00};
      for (int i = 23; i >= 8; i--) begin
         if (rem[i]) rem[i -: 9] = rem[i -: 9] ^ 9'h107;
      end
      return rem[7:0];
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic start_test();
      t0      = cyc;
      n_ack   = 0;
      n_rd    = 0;
      n_stv   = 0;
      ack_cyc = -1;
      rd_cyc  = -1;
      stv_cyc = -1;
   endtask

   // Upstream model: req held until ack seen, cleared the cycle after; addr scrambled once latched.
   task automatic serve(input logic [6:0] a, input int busy_len, input int drop_at, input int ncyc);
      logic acked;
      acked = 1'b0;
      start_test();
      for (int r = 0; r < ncyc; r++) begin
         busy = (r < busy_len);
         req  = !acked && (drop_at < 0 || r < drop_at);
         addr = (r <= busy_len) ? a : ~a;
         if (ack) acked = 1'b1;
         tick();
      end
      req  = 1'b0;
      busy = 1'b0;
   endtask

   task automatic serve_check(input string tag, input logic [6:0] a, input int busy_len,
                              input int exp_stv_cyc, input logic exp_inj);
      logic [7:0] d;
      d = mem[a];
      serve(a, busy_len, -1, busy_len + 10);
      check_eq({tag, " rd_en count"}, n_rd, 1);
      check_eq({tag, " rd_en cycle"}, rd_cyc, 1 + busy_len);
      check_eq({tag, " rd_addr"}, {25'd0, rd_addr_seen}, {25'd0, a});
      check_eq({tag, " ack count"}, n_ack, 1);
      check_eq({tag, " ack cycle"}, ack_cyc, 2 + RD_LAT + busy_len);
      check_eq({tag, " data"}, {24'd0, ack_data}, {24'd0, d});
      check_eq({tag, " crc"}, {24'd0, ack_crc},
               {24'd0, crc_model({1'b1, a, d}) ^ {7'd0, exp_inj}});
      check_eq({tag, " starve count"}, n_stv, (exp_stv_cyc < 0) ? 0 : 1);
      check_eq({tag, " starve cycle"}, stv_cyc, exp_stv_cyc);
      check_eq({tag, " data held"}, {24'd0, rsp_data}, {24'd0, d});
   endtask

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 8'(i * 3) ^ 8'h3C;
      mem[7'h0B] = 8'h5A;
      start_test();

      i_rst = 1'b1;
      repeat (3) tick();
      check_eq("reset outputs", {6'd0, ack, rsp_data, rsp_crc, rd_en, rd_addr, starve}, 32'd0);
      i_rst = 1'b0;
      tick();

      // 1: idle bus, minimum latency
      serve_check("t1", 7'h0B, 0, -1, 1'b0);
      check_eq("t1 data literal", {24'd0, ack_data}, 32'h5A);

      // 2: SPI busy for cycles 0..4
      serve_check("t2", 7'h30, 5, -1, 1'b0);

      // 3: starvation pulse while SPI holds the bank for 20 cycles
      serve_check("t3", 7'h44, 20, WAIT_MAX, 1'b0);

      // 4a: req withdrawn while waiting for the bus
      serve(7'h55, 10, 2, 16);
      check_eq("t4a ack count", n_ack, 0);
      check_eq("t4a rd_en count", n_rd, 0);

      // 4b: req withdrawn while the read is in flight
      serve(7'h11, 0, 1, 8);
      check_eq("t4b ack count", n_ack, 0);
      check_eq("t4b rd_en count", n_rd, 1);

      serve_check("t4c", 7'h01, 0, -1, 1'b0);

      // 5: reset lands mid-read with req still held
      start_test();
      busy = 1'b0;
      req  = 1'b1;
      addr = 7'h22;
      tick();
      check_eq("t5 rd_en before reset", {31'd0, rd_en}, 32'd1);
      i_rst = 1'b1;
      tick();
      check_eq("t5 outputs after reset",
               {6'd0, ack, rsp_data, rsp_crc, rd_en, rd_addr, starve}, 32'd0);
      i_rst = 1'b0;
      serve_check("t5", 7'h22, 0, -1, 1'b0);

`ifdef LV_WDG_SCAN_CRC_INJ_EN
      // 6: forced CRC error, then clean CRC again
      crc_inj = 1'b1;
      serve_check("t6 inj", 7'h2B, 0, -1, 1'b1);
      crc_inj = 1'b0;
      serve_check("t6 clean", 7'h2B, 0, -1, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
